spi_host_link: RTL and testbench

- SPI controller (initiator) for the accelerator's SPI target port.
- Board-side and test logic use it to stream move bytes into the accelerator and to clock result bytes back out.
- Byte-oriented with a valid/ready transmit stream and a pulsed receive stream.
- Chip-select is framed by a per-byte "last" flag.
- SPI Mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.

---
 rtl/spi_host_link.sv | 159 +++++++++++++++
 tb/tb_spi_host_link.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_link.sv
// SPI Mode 0 controller: byte-wide valid/ready transmit stream in, one-cycle
// receive pulse out, chip-select framed by the per-byte last flag. MSB first,
// full duplex. CLK_DIV sets the SCK half-period in clk cycles and GAP_CYC sets
// the minimum cs_n high time between frames.
module spi_host_link #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] byte_cnt,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    // Counters count down to zero, so the reload is one less than the length.
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYC - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [7:0] gap_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] tx_sr;      // bits still to go out after the one on mosi
    logic [7:0] rx_sr;
    logic       last_flag;
    logic       handshake;

    assign handshake = tx_valid & tx_ready;

    // Frame byte counter stops at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Transfer sequencer: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= S_IDLE;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
            byte_cnt <= 8'd0;
            busy     <= 1'b0;
            div_cnt  <= 8'd0;
            gap_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE, S_NEXT: begin
                    if (handshake) begin
                        // A fresh frame restarts the count; a continuation keeps it.
                        if (state == S_IDLE) byte_cnt <= 8'd0;
                        state     <= S_SETUP;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        tx_ready  <= 1'b0;
                        div_cnt   <= DIV_RELOAD;
                        mosi      <= tx_data[7];
                        tx_sr     <= tx_data[6:0];
                        last_flag <= tx_last;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (div_cnt == 8'd0) begin
                        // First rising SCK edge: target samples bit7, we sample miso.
                        state   <= S_SHIFT;
                        sclk    <= 1'b1;
                        rx_sr   <= {rx_sr[6:0], miso};
                        bit_cnt <= 3'd0;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_RELOAD;
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                // Falling edge after bit0 closes the byte; no trailing low phase.
                                rx_valid <= 1'b1;
                                rx_data  <= rx_sr;
                                byte_cnt <= sat_inc(byte_cnt);
                                if (last_flag) begin
                                    state <= S_HOLD;
                                end else begin
                                    state    <= S_NEXT;
                                    tx_ready <= 1'b1;
                                end
                            end else begin
                                mosi    <= tx_sr[6];
                                tx_sr   <= {tx_sr[5:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[6:0], miso};
                        end
                    end
                end

                S_HOLD: begin
                    if (div_cnt == 8'd0) begin
                        cs_n    <= 1'b1;
                        state   <= S_GAP;
                        gap_cnt <= GAP_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_link.sv
// Bench for spi_host_link: two instances (CLK_DIV=2/GAP_CYC=4 and
// CLK_DIV=1/GAP_CYC=1) driven by directed frames, checked every cycle against
// a timeline model and by hand-computed literal expectations.
module tb_spi_host_link;

    localparam int CD_A  = 2;
    localparam int GAP_A = 4;
    localparam int CD_B  = 1;
    localparam int GAP_B = 1;

    localparam int M_IDLE = 0;
    localparam int M_BYTE = 1;
    localparam int M_NEXT = 2;
    localparam int M_TAIL = 3;

    localparam int BOUND = 3000;

    logic            clk = 1'b0;
    logic [1:0]      nrst;
    logic [1:0]      tx_valid;
    logic [1:0]      tx_last;
    logic [1:0][7:0] tx_data;
    logic [1:0]      loop_en;
    logic [1:0]      miso_c;

    wire  [1:0]      tx_ready;
    wire  [1:0]      rx_valid;
    wire  [1:0]      busy;
    wire  [1:0]      sclk;
    wire  [1:0]      cs_n;
    wire  [1:0]      mosi;
    wire  [1:0]      miso;
    wire  [1:0][7:0] rx_data;
    wire  [1:0][7:0] byte_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign miso[0] = loop_en[0] ? mosi[0] : miso_c[0];
    assign miso[1] = loop_en[1] ? mosi[1] : miso_c[1];

    spi_host_link #(.CLK_DIV(CD_A), .GAP_CYC(GAP_A)) dut_a (
        .clk(clk), .nrst(nrst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_last(tx_last[0]), .tx_ready(tx_ready[0]), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .byte_cnt(byte_cnt[0]), .busy(busy[0]),
        .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    spi_host_link #(.CLK_DIV(CD_B), .GAP_CYC(GAP_B)) dut_b (
        .clk(clk), .nrst(nrst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_last(tx_last[1]), .tx_ready(tx_ready[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .byte_cnt(byte_cnt[1]), .busy(busy[1]),
        .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    function automatic int cd_of(input int k);
        return (k == 0) ? CD_A : CD_B;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? GAP_A : GAP_B;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc=%0d got %0h want %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int k);
        n_vec++;
        n_bad++;
        $display("FAIL %s[%0d] cyc=%0d got no event want event within %0d cycles", nm, k, cyc, BOUND);
    endtask

    // Model: where each instance is on the frame timeline, counted in clk edges.
    int              m_st[2];
    int              m_t[2];
    logic [1:0]      m_rdy;
    logic [1:0]      m_rxv;
    logic [1:0]      m_last;
    logic [1:0][7:0] m_byte;
    logic [1:0][7:0] m_cnt;
    logic [1:0][7:0] m_rxd;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!nrst[k]) begin
                m_st[k]  <= M_IDLE;
                m_t[k]   <= 0;
                m_rdy[k] <= 1'b0;
                m_rxv[k] <= 1'b0;
                m_rxd[k] <= 8'd0;
                m_cnt[k] <= 8'd0;
            end else begin
                m_rxv[k] <= 1'b0;
                case (m_st[k])
                    M_IDLE, M_NEXT: begin
                        if (tx_valid[k] && m_rdy[k]) begin
                            if (m_st[k] == M_IDLE) m_cnt[k] <= 8'd0;
                            m_st[k]   <= M_BYTE;
                            m_t[k]    <= 0;
                            m_rdy[k]  <= 1'b0;
                            m_byte[k] <= tx_data[k];
                            m_last[k] <= tx_last[k];
                        end else begin
                            m_rdy[k] <= 1'b1;
                        end
                    end
                    M_BYTE: begin
                        if (m_t[k] + 1 == 16 * cd_of(k)) begin
                            m_rxv[k] <= 1'b1;
                            m_rxd[k] <= loop_en[k] ? m_byte[k] : {8{miso_c[k]}};
                            m_cnt[k] <= (m_cnt[k] == 8'hFF) ? 8'hFF : m_cnt[k] + 8'd1;
                            if (m_last[k]) begin
                                m_st[k] <= M_TAIL;
                                m_t[k]  <= 0;
                            end else begin
                                m_st[k]  <= M_NEXT;
                                m_rdy[k] <= 1'b1;
                            end
                        end else begin
                            m_t[k] <= m_t[k] + 1;
                        end
                    end
                    default: begin
                        if (m_t[k] + 1 == cd_of(k) + gap_of(k)) begin
                            m_st[k]  <= M_IDLE;
                            m_rdy[k] <= 1'b1;
                        end else begin
                            m_t[k] <= m_t[k] + 1;
                        end
                    end
                endcase
            end
        end
    end

    // Compare every DUT output with the model on the falling edge.
    always @(negedge clk) begin : cmp
        int   c;
        int   t;
        logic e_cs;
        logic e_sclk;
        logic e_busy;
        logic e_rdy;
        for (int k = 0; k < 2; k++) begin
            c = cd_of(k);
            t = m_t[k];
            case (m_st[k])
                M_IDLE: begin
                    e_cs = 1'b1; e_sclk = 1'b0; e_busy = 1'b0; e_rdy = m_rdy[k];
                end
                M_BYTE: begin
                    e_cs = 1'b0; e_busy = 1'b1; e_rdy = 1'b0;
                    e_sclk = (t >= c) && (((t - c) % (2 * c)) < c);
                    chk("mosi", k, mosi[k], m_byte[k][7 - t / (2 * c)]);
                end
                M_NEXT: begin
                    e_cs = 1'b0; e_sclk = 1'b0; e_busy = 1'b1; e_rdy = 1'b1;
                end
                default: begin
                    e_cs = (t >= c); e_sclk = 1'b0; e_busy = 1'b1; e_rdy = 1'b0;
                end
            endcase
            chk("cs_n", k, cs_n[k], e_cs);
            chk("sclk", k, sclk[k], e_sclk);
            chk("busy", k, busy[k], e_busy);
            chk("tx_ready", k, tx_ready[k], e_rdy);
            chk("rx_valid", k, rx_valid[k], m_rxv[k]);
            chk("rx_data", k, rx_data[k], m_rxd[k]);
            chk("byte_cnt", k, byte_cnt[k], m_cnt[k]);
        end
    end

    // Event counters used by the literal checks.
    logic [1:0]      sclk_q = 2'b00;
    logic [1:0][7:0] mosi_sh;
    int              rises[2];
    int              rx_tot[2];
    int              csh_tot[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sclk[k] === 1'b1 && sclk_q[k] === 1'b0) begin
                mosi_sh[k] <= {mosi_sh[k][6:0], mosi[k]};
                rises[k]   <= rises[k] + 1;
            end
            sclk_q[k] <= sclk[k];
            if (rx_valid[k] === 1'b1) rx_tot[k] <= rx_tot[k] + 1;
            if (cs_n[k] === 1'b1) csh_tot[k] <= csh_tot[k] + 1;
        end
    end

    // Offer one byte from a falling edge; hs is the edge count of the handshake.
    task automatic send(input int k, input logic [7:0] d, input logic l, output int hs);
        tx_data[k]  = d;
        tx_last[k]  = l;
        tx_valid[k] = 1'b1;
        hs = -1;
        for (int i = 0; i < BOUND; i++) begin
            if (tx_ready[k] === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        tx_valid[k] = 1'b0;
        tx_data[k]  = ~d;
        if (hs < 0) timeout("send", k);
    endtask

    task automatic wait_rx(input int k, output int c);
        c = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (rx_valid[k] === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("wait_rx", k);
    endtask

    task automatic wait_cs_high(input int k, output int c);
        c = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (cs_n[k] === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("wait_cs_high", k);
    endtask

    task automatic wait_idle(input int k, output int c);
        c = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (busy[k] === 1'b0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("wait_idle", k);
    endtask

    initial begin
        int hs, hs2, c, c2, c3, base, rb, csb, n;
        logic prev;

        nrst     = 2'b00;
        tx_valid = 2'b00;
        tx_last  = 2'b00;
        tx_data  = '0;
        loop_en  = 2'b11;
        miso_c   = 2'b00;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_sclk", k, sclk[k], 1'b0);
            chk("rst_cs_n", k, cs_n[k], 1'b1);
            chk("rst_mosi", k, mosi[k], 1'b0);
            chk("rst_tx_ready", k, tx_ready[k], 1'b0);
            chk("rst_rx_valid", k, rx_valid[k], 1'b0);
            chk("rst_rx_data", k, rx_data[k], 8'h00);
            chk("rst_byte_cnt", k, byte_cnt[k], 8'h00);
            chk("rst_busy", k, busy[k], 1'b0);
        end
        nrst = 2'b11;
        @(negedge clk);
        chk("ready_after_rst", 0, tx_ready[0], 1'b1);

        // Loopback single byte 0xA5.
        send(0, 8'hA5, 1'b1, hs);
        base = rises[0];
        wait_rx(0, c);
        chk("a5_latency", 0, c - hs, 32);
        chk("a5_rx_data", 0, rx_data[0], 8'hA5);
        chk("a5_byte_cnt", 0, byte_cnt[0], 8'd1);
        wait_cs_high(0, c2);
        chk("a5_cs_rise", 0, c2 - c, 2);
        wait_idle(0, c3);
        chk("a5_busy_fall", 0, c3 - c, 2 + GAP_A);
        chk("a5_mosi_bits", 0, mosi_sh[0], 8'hA5);
        chk("a5_sclk_rises", 0, rises[0] - base, 8);

        // Three-byte frame with miso tied high.
        loop_en[0] = 1'b0;
        miso_c[0]  = 1'b1;
        repeat (2) @(negedge clk);
        rb = rx_tot[0];
        send(0, 8'h01, 1'b0, hs);
        csb = csh_tot[0];
        wait_rx(0, c);
        chk("f3_rx1", 0, rx_data[0], 8'hFF);
        chk("f3_cnt1", 0, byte_cnt[0], 8'd1);
        send(0, 8'h02, 1'b0, hs);
        wait_rx(0, c);
        chk("f3_rx2", 0, rx_data[0], 8'hFF);
        chk("f3_cnt2", 0, byte_cnt[0], 8'd2);
        send(0, 8'h83, 1'b1, hs);
        wait_rx(0, c);
        chk("f3_rx3", 0, rx_data[0], 8'hFF);
        chk("f3_cnt3", 0, byte_cnt[0], 8'd3);
        chk("f3_cs_glitch", 0, csh_tot[0] - csb, 0);
        wait_idle(0, c3);
        repeat (2) @(negedge clk);
        chk("f3_rx_pulses", 0, rx_tot[0] - rb, 3);
        chk("f3_cnt_held", 0, byte_cnt[0], 8'd3);

        // Stall in NEXT for 100 cycles.
        loop_en[0] = 1'b1;
        send(0, 8'h11, 1'b0, hs);
        wait_rx(0, c);
        repeat (100) @(negedge clk);
        chk("stall_cs_n", 0, cs_n[0], 1'b0);
        chk("stall_sclk", 0, sclk[0], 1'b0);
        chk("stall_ready", 0, tx_ready[0], 1'b1);
        chk("stall_busy", 0, busy[0], 1'b1);
        send(0, 8'h3C, 1'b1, hs);
        wait_rx(0, c);
        chk("stall_rx", 0, rx_data[0], 8'h3C);
        chk("stall_cnt", 0, byte_cnt[0], 8'd2);
        wait_idle(0, c3);

        // Request while shifting is ignored.
        rb = rx_tot[0];
        send(0, 8'h6E, 1'b1, hs);
        repeat (10) @(negedge clk);
        tx_data[0]  = 8'hFF;
        tx_last[0]  = 1'b0;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        wait_idle(0, c3);
        repeat (4) @(negedge clk);
        chk("ign_rx_pulses", 0, rx_tot[0] - rb, 1);
        chk("ign_rx_data", 0, rx_data[0], 8'h6E);
        chk("ign_byte_cnt", 0, byte_cnt[0], 8'd1);
        chk("ign_busy", 0, busy[0], 1'b0);

        // Reset after three rising SCK edges of the second byte of a frame.
        send(0, 8'h11, 1'b0, hs);
        wait_rx(0, c);
        send(0, 8'hC3, 1'b1, hs);
        prev = sclk[0];
        n = 0;
        for (int i = 0; i < BOUND && n < 3; i++) begin
            @(negedge clk);
            if (sclk[0] === 1'b1 && prev === 1'b0) n++;
            prev = sclk[0];
        end
        chk("rst_mid_rises", 0, n, 3);
        nrst[0] = 1'b0;
        rb = rx_tot[0];
        @(negedge clk);
        chk("mid_cs_n", 0, cs_n[0], 1'b1);
        chk("mid_sclk", 0, sclk[0], 1'b0);
        chk("mid_byte_cnt", 0, byte_cnt[0], 8'd0);
        chk("mid_rx_valid", 0, rx_valid[0], 1'b0);
        chk("mid_busy", 0, busy[0], 1'b0);
        nrst[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_no_pulse", 0, rx_tot[0] - rb, 0);
        send(0, 8'h5A, 1'b1, hs);
        wait_rx(0, c);
        chk("post_rst_latency", 0, c - hs, 32);
        chk("post_rst_rx", 0, rx_data[0], 8'h5A);
        chk("post_rst_cnt", 0, byte_cnt[0], 8'd1);
        wait_idle(0, c3);

        // CLK_DIV=1, GAP_CYC=1 back-to-back frames.
        base = rises[1];
        send(1, 8'h96, 1'b1, hs);
        wait_rx(1, c);
        chk("b_lat1", 1, c - hs, 16);
        chk("b_rx1", 1, rx_data[1], 8'h96);
        send(1, 8'h3A, 1'b1, hs2);
        chk("b_hs_spacing", 1, hs2 - hs, 19);
        wait_rx(1, c);
        chk("b_lat2", 1, c - hs2, 16);
        chk("b_rx2", 1, rx_data[1], 8'h3A);
        wait_idle(1, c3);
        chk("b_sclk_rises", 1, rises[1] - base, 16);
        chk("b_mosi_bits", 1, mosi_sh[1], 8'h3A);

        // 257-byte frame drives byte_cnt into saturation.
        for (int i = 0; i < 257; i++) begin
            send(1, 8'(i), (i == 256), hs);
            wait_rx(1, c);
            if (i == 254) chk("sat_cnt_255", 1, byte_cnt[1], 8'd255);
        end
        chk("sat_cnt_hold", 1, byte_cnt[1], 8'd255);
        chk("sat_rx_last", 1, rx_data[1], 8'h00);
        wait_idle(1, c3);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
